vga_movimg_gen: RTL and testbench
=================================

Name: vga_movimg_gen

Overview:
- Pixel-generation stage directly downstream of the 640x480 VGA timing generator.
- Consumes the timing block's valid, h_cnt, v_cnt, hsync and vsync. Outputs RGB444 plus hsync/vsync delayed to match its pipeline.
- Draws an IMG_W x IMG_H sprite, fetched from an external synchronous ROM, over a solid background.
- The sprite moves across the 640x480 active area and bounces off the edges once every SPEED frames.

Parameters:
- IMG_W, 64, sprite width in pixels; must be a power of 2.
- IMG_H, 64, sprite height in pixels.
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- SPEED, 2, number of frames between position updates; must be >= 1.
- STEP, 2, pixels moved per update on each axis; must be >= 1.
- BG_COLOR, 12'h000, RGB444 background colour.

Ports:
- pclk  in  1  pixel clock, 25.175 MHz domain.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  active-area flag from the timing stage.
- h_cnt  in  10  active x coordinate, 0..639.
- v_cnt  in  10  active y coordinate, 0..479.
- hsync_in  in  1  hsync from the timing stage; low during the sync pulse.
- vsync_in  in  1  vsync from the timing stage; low during the sync pulse.
- pause  in  1  when high, freezes the sprite position.
- rom_addr  out  ADDR_W  sprite ROM address, registered.
- rom_data  in  12  ROM output; valid one pclk after rom_addr.
- vga_r, vga_g, vga_b  out  4 each  colour outputs, registered.
- hsync, vsync  out  1 each  sync outputs delayed by 3 pclk.

Behaviour:
- Clocking: single clock, pclk. All state is updated on the pclk rising edge. reset is synchronous and active-high.
- Reset values:
  - rom_addr = 0; vga_r/g/b = 0.
  - hsync = vsync = 1, as are all sync delay stages.
  - x_pos = 0, y_pos = 0, dx = dy = 1 (positive direction).
  - frame_cnt = 0, vsync_q = 1.
  - Reset asserted mid-frame takes effect at the next edge and overrides every other update.
- Pipeline: 3 cycles, inputs at edge N to RGB output after edge N+3.
  - S1 (edge N+1):
    - in_spr = valid && h_cnt in [x_pos, x_pos+IMG_W-1] && v_cnt in [y_pos, y_pos+IMG_H-1].
    - rom_addr = {(v_cnt-y_pos), (h_cnt-x_pos)[log2(IMG_W)-1:0]}, truncated to ADDR_W.
    - rom_addr is held at 0 when in_spr=0.
    - S1 also registers valid and in_spr.
  - S2 (edge N+2): the ROM returns rom_data. valid and in_spr are delayed one more stage.
  - S3 (edge N+3): {vga_r,vga_g,vga_b} is registered as:
    - 0 if valid=0;
    - else rom_data if in_spr=1;
    - else BG_COLOR.
  - hsync and vsync pass through a 3-stage shift register, so they stay aligned with RGB.
- Comparisons use 11-bit arithmetic, so x_pos+IMG_W cannot overflow.
- Frame tick:
  - vsync_q <= vsync_in every cycle.
  - tick = vsync_in && !vsync_q, i.e. the rising edge at the end of the sync pulse. This falls outside the active area, so position never changes mid-frame.
- Frame counter: on tick, if frame_cnt == SPEED-1 then frame_cnt <= 0 and a move occurs; otherwise frame_cnt increments.
- pause=1 blocks only the move itself; frame_cnt still counts.
- Move, X axis (XMAX = 640-IMG_W):
  - dx=1: if x_pos+STEP >= XMAX then x_pos <= XMAX and dx <= 0; else x_pos += STEP.
  - dx=0: if x_pos <= STEP then x_pos <= 0 and dx <= 1; else x_pos -= STEP.
  - The sprite never leaves [0, XMAX].
- Move, Y axis: same rules with y_pos, dy and YMAX = 480-IMG_H.
- X and Y are updated in the same cycle and independently.
- A corner hit reverses both directions in that one update.

Optional Feature:
- Macro: MOVIMG_WRAP_EN.
- Defined (wrap mode):
  - Movement is positive only; dx and dy are held at 1.
  - If x_pos+STEP > XMAX then x_pos <= 0, else x_pos += STEP. Y wraps the same way against YMAX.
- Undefined: bounce behaviour exactly as specified under Behaviour.

Test Plan:
- Reset for 2 cycles mid-line → next cycle: RGB = 0, hsync = vsync = 1, x_pos = y_pos = 0, dx = dy = 1, rom_addr = 0.
- Drive valid=1, h_cnt=5, v_cnt=3 with the sprite at (0,0) and ROM returning 12'hABC → rom_addr = 3*64+5 = 197 one cycle later; RGB = A,B,C exactly 3 cycles after the input. Then h_cnt=64 → BG_COLOR at 3 cycles; valid=0 → 0.
- Send 4 vsync rising edges with SPEED=2, STEP=2 → exactly 2 moves: x_pos = y_pos = 4. No update occurs on vsync falling edges or while vsync_in is steady.
- Preload x_pos=575, dx=1 with XMAX=576 → after one move x_pos=576, dx=0; after the next move x_pos=574. Same check at y_pos=0 with dy=0 → y_pos=0, dy=1.
- pause=1 across 6 ticks → position unchanged. Release pause → next qualifying tick moves the sprite by STEP.
- With MOVIMG_WRAP_EN: x_pos=575, STEP=2 → x_pos=0 and dx stays 1. Also check hsync_in/vsync_in pulses appear on hsync/vsync exactly 3 cycles later, in all builds.

Source files
------------

// File: rtl/vga_movimg_gen.sv
// Sprite pixel generator for the 640x480 VGA timing chain: ROM-fetched sprite over a solid background.
// Define MOVIMG_WRAP_EN for wrap-around motion instead of edge bounce.
module vga_movimg_gen #(
  parameter int          IMG_W    = 64,
  parameter int          IMG_H    = 64,
  parameter int          ADDR_W   = 12,
  parameter int          SPEED    = 2,
  parameter int          STEP     = 2,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              valid,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync
);

  localparam int          XB      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          FCW     = (SPEED > 1) ? $clog2(SPEED) : 1;
  localparam logic [10:0] W11     = 11'(IMG_W);
  localparam logic [10:0] H11     = 11'(IMG_H);
  localparam logic [10:0] XMAX    = 11'(640 - IMG_W);
  localparam logic [10:0] YMAX    = 11'(480 - IMG_H);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [FCW-1:0] FC_LAST = FCW'(SPEED - 1);

`ifdef MOVIMG_WRAP_EN
  // Returns {dir, pos}; motion is positive only and restarts at 0 past the limit.
  function automatic logic [11:0] axis_move(input logic [10:0] pos, input logic [10:0] maxp);
    if (pos + STEP11 > maxp) return {1'b1, 11'd0};
    return {1'b1, pos + STEP11};
  endfunction
`else
  // Returns {dir, pos}; clamps to [0, maxp] and reverses direction on contact.
  function automatic logic [11:0] axis_move(input logic [10:0] pos, input logic dir,
                                            input logic [10:0] maxp);
    if (dir) begin
      if (pos + STEP11 >= maxp) return {1'b0, maxp};
      return {1'b1, pos + STEP11};
    end
    if (pos <= STEP11) return {1'b1, 11'd0};
    return {1'b0, pos - STEP11};
  endfunction
`endif

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              vld_p1, spr_p1, vld_p2, spr_p2;
  logic [11:0]       rgb_q, rgb_d;
  logic [2:0]        hs_q, vs_q;
  logic              vsync_q;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [10:0]       x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic              dx_q, dx_d, dy_q, dy_d;

  logic [10:0]       h11, v11, voff;
  logic [XB-1:0]     hoff;
  logic              in_spr_d, tick;
  logic [11:0]       x_mv, y_mv;

  always_comb begin
    h11      = {1'b0, h_cnt};
    v11      = {1'b0, v_cnt};
    in_spr_d = valid && (h11 >= x_pos_q) && (h11 < x_pos_q + W11)
                     && (v11 >= y_pos_q) && (v11 < y_pos_q + H11);
    hoff       = XB'(h11 - x_pos_q);
    voff       = v11 - y_pos_q;
    rom_addr_d = in_spr_d ? ADDR_W'({voff, hoff}) : '0;

    if (!vld_p2)     rgb_d = 12'h000;
    else if (spr_p2) rgb_d = rom_data;
    else             rgb_d = BG_COLOR;

`ifdef MOVIMG_WRAP_EN
    x_mv = axis_move(x_pos_q, XMAX);
    y_mv = axis_move(y_pos_q, YMAX);
`else
    x_mv = axis_move(x_pos_q, dx_q, XMAX);
    y_mv = axis_move(y_pos_q, dy_q, YMAX);
`endif

    // End of the vsync pulse lies in blanking, so position never changes mid-frame.
    tick        = vsync_in && !vsync_q;
    frame_cnt_d = frame_cnt_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    if (tick) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        if (!pause) begin
          x_pos_d = x_mv[10:0];
          dx_d    = x_mv[11];
          y_pos_d = y_mv[10:0];
          dy_d    = y_mv[11];
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      rgb_q       <= 12'h000;
      hs_q        <= 3'b111;
      vs_q        <= 3'b111;
      vsync_q     <= 1'b1;
      frame_cnt_q <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
    end else begin
      // S1: hit test and ROM address
      rom_addr_q  <= rom_addr_d;
      vld_p1      <= valid;
      // S2: ROM data arrives
      vld_p2      <= vld_p1;
      // S3: colour select
      rgb_q       <= rgb_d;
      hs_q        <= {hs_q[1:0], hsync_in};
      vs_q        <= {vs_q[1:0], vsync_in};
      vsync_q     <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
    end
  end

  always_ff @(posedge pclk) begin
    spr_p1 <= in_spr_d;
    spr_p2 <= spr_p1;
  end

  assign rom_addr = rom_addr_q;
  assign vga_r    = rgb_q[11:8];
  assign vga_g    = rgb_q[7:4];
  assign vga_b    = rgb_q[3:0];
  assign hsync    = hs_q[2];
  assign vsync    = vs_q[2];

endmodule

// File: tb/tb_vga_movimg_gen.sv
// Bench for vga_movimg_gen: per-cycle comparison against a coordinate-level model plus directed literals.
module tb_vga_movimg_gen;

  localparam int          SPEED_P = 2;
  localparam int          STEP_P  = 2;
  localparam logic [11:0] BG      = 12'h1E7;
  localparam int          XMAX_M  = 640 - 64;
  localparam int          YMAX_M  = 480 - 64;

  logic        pclk = 1'b0;
  logic        reset, valid, hsync_in, vsync_in, pause;
  logic [9:0]  h_cnt, v_cnt;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync;

  int n_cmp = 0;
  int n_bad = 0;

  vga_movimg_gen #(.IMG_W(64), .IMG_H(64), .ADDR_W(12), .SPEED(SPEED_P), .STEP(STEP_P),
                   .BG_COLOR(BG)) dut (
    .pclk(pclk), .reset(reset), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
  );

  always #20 pclk = ~pclk;

  function automatic logic [11:0] rom_fn(input int a);
    if (a == 197) return 12'hABC;
    return 12'((a * 37) + 291);
  endfunction

  always @(posedge pclk) rom_data <= rom_fn(int'(rom_addr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sprite position in plain integers, updated by the movement rules.
  int mx, my, mfc;
  bit mdx, mdy, mvsq;

  task automatic mv(inout int p, inout bit d, input int maxp);
`ifdef MOVIMG_WRAP_EN
    p = (p + STEP_P > maxp) ? 0 : p + STEP_P;
    d = 1'b1;
`else
    if (d) begin
      if (p + STEP_P >= maxp) begin p = maxp; d = 1'b0; end
      else p = p + STEP_P;
    end else begin
      if (p <= STEP_P) begin p = 0; d = 1'b1; end
      else p = p - STEP_P;
    end
`endif
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } ent_t;

  ent_t h0, h1, h2, e;
  bit   armed = 1'b0;

  always @(negedge pclk) begin
    if (armed) begin
      chk("rom_addr", 32'(rom_addr), 32'(h0.addr));
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(h2.rgb));
      chk("hsync", 32'(hsync), 32'(h2.hs));
      chk("vsync", 32'(vsync), 32'(h2.vs));
      chk("x_pos", 32'(dut.x_pos_q), 32'(mx));
      chk("y_pos", 32'(dut.y_pos_q), 32'(my));
      chk("dx", 32'(dut.dx_q), 32'(mdx));
      chk("dy", 32'(dut.dy_q), 32'(mdy));
    end
    if (reset) begin
      e.addr = 12'h000; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
      h0 = e; h1 = e; h2 = e;
      armed = 1'b1;
      mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mfc = 0; mvsq = 1'b1;
    end else begin
      int hh, vv;
      bit ins;
      hh  = int'(h_cnt);
      vv  = int'(v_cnt);
      ins = valid && hh >= mx && hh < mx + 64 && vv >= my && vv < my + 64;
      e.addr = ins ? 12'((vv - my) * 64 + (hh - mx)) : 12'h000;
      e.rgb  = !valid ? 12'h000 : (ins ? rom_fn(int'(e.addr)) : BG);
      e.hs   = hsync_in;
      e.vs   = vsync_in;
      h2 = h1; h1 = h0; h0 = e;
      if (vsync_in && !mvsq) begin
        if (mfc == SPEED_P - 1) begin
          mfc = 0;
          if (!pause) begin
            mv(mx, mdx, XMAX_M);
            mv(my, mdy, YMAX_M);
          end
        end else begin
          mfc = mfc + 1;
        end
      end
      mvsq = vsync_in;
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick_pulse();
    vsync_in = 1'b0; cyc();
    vsync_in = 1'b1; cyc();
  endtask

  task automatic do_move();
    repeat (SPEED_P) tick_pulse();
  endtask

  task automatic scan();
    int pdx[10] = '{-1, 0, 63, 64, 0, 0, 63, 10, 20, -5};
    int pdy[10] = '{0, 0, 0, 0, 63, 64, 63, -1, 30, 70};
    for (int i = 0; i < 10; i++) begin
      int hh, vv;
      hh = mx + pdx[i];
      vv = my + pdy[i];
      if (hh >= 0 && hh <= 639 && vv >= 0 && vv <= 479) begin
        valid = 1'b1; h_cnt = 10'(hh); v_cnt = 10'(vv);
        cyc();
      end
    end
    valid = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; h_cnt = '0; v_cnt = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; pause = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;

    // Mid-line activity, then a two-cycle reset.
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h_cnt = 10'(2 + i); v_cnt = 10'd1; hsync_in = (i != 1);
      cyc();
    end
    hsync_in = 1'b1;
    reset = 1'b1; cyc(); cyc();
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_x", 32'(dut.x_pos_q), 32'd0);
    chk("rst_dx", 32'(dut.dx_q), 32'd1);

    // Sprite at (0,0): pixel (5,3), then background, then blanking.
    reset = 1'b0; valid = 1'b1; h_cnt = 10'd5; v_cnt = 10'd3;
    cyc();
    chk("addr_197", 32'(rom_addr), 32'd197);
    h_cnt = 10'd64; cyc();
    valid = 1'b0; cyc();
    chk("rgb_abc", 32'({vga_r, vga_g, vga_b}), 32'hABC);
    cyc();
    chk("rgb_bg", 32'({vga_r, vga_g, vga_b}), 32'(BG));
    cyc();
    chk("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'h0);

    hsync_in = 1'b0; cyc();
    hsync_in = 1'b1; cyc();
    chk("hs_d2", 32'(hsync), 32'h1);
    cyc();
    chk("hs_d3", 32'(hsync), 32'h0);
    cyc();
    chk("hs_d4", 32'(hsync), 32'h1);

    // Four frame ticks -> two moves; the first also checks vsync delay.
    vsync_in = 1'b0; cyc();
    vsync_in = 1'b1; cyc();
    chk("tick1_x", 32'(dut.x_pos_q), 32'd0);
    cyc();
    chk("vs_d3", 32'(vsync), 32'h0);
    cyc();
    chk("vs_d4", 32'(vsync), 32'h1);
    tick_pulse();
    chk("tick2_x", 32'(dut.x_pos_q), 32'd2);
    tick_pulse(); repeat (2) cyc(); tick_pulse();
    chk("tick4_x", 32'(dut.x_pos_q), 32'd4);
    chk("tick4_y", 32'(dut.y_pos_q), 32'd4);
    scan();

    pause = 1'b1;
    repeat (6) tick_pulse();
    chk("pause_x", 32'(dut.x_pos_q), 32'd4);
    chk("pause_y", 32'(dut.y_pos_q), 32'd4);
    pause = 1'b0;
    tick_pulse();
    chk("unpause1_x", 32'(dut.x_pos_q), 32'd4);
    tick_pulse();
    chk("unpause2_x", 32'(dut.x_pos_q), 32'd6);
    chk("unpause2_y", 32'(dut.y_pos_q), 32'd6);

    // Edge behaviour from a fresh start.
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0; cyc();
    repeat (288) do_move();
    chk("edge_x", 32'(dut.x_pos_q), 32'd576);
`ifdef MOVIMG_WRAP_EN
    chk("edge_dx", 32'(dut.dx_q), 32'd1);
    chk("edge_y", 32'(dut.y_pos_q), 32'd158);
    scan();
    do_move();
    chk("wrap_x", 32'(dut.x_pos_q), 32'd0);
    chk("wrap_dx", 32'(dut.dx_q), 32'd1);
    chk("wrap_y", 32'(dut.y_pos_q), 32'd160);
`else
    chk("edge_dx", 32'(dut.dx_q), 32'd0);
    chk("edge_y", 32'(dut.y_pos_q), 32'd256);
    chk("edge_dy", 32'(dut.dy_q), 32'd0);
    scan();
    do_move();
    chk("back_x", 32'(dut.x_pos_q), 32'd574);
    chk("back_y", 32'(dut.y_pos_q), 32'd254);
    repeat (127) do_move();
    chk("top_y", 32'(dut.y_pos_q), 32'd0);
    chk("top_dy", 32'(dut.dy_q), 32'd1);
    chk("top_x", 32'(dut.x_pos_q), 32'd320);
    scan();
`endif

    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
